// File: rtl/decimator.sv
// Sample-rate reducer: one output per 2^k valid samples in sample, average or
// min/max envelope mode, with ratio and mode latched on block boundaries.
module decimator #(
  parameter int WIDTH    = 8,
  parameter int MAX_LOG2 = 14,
  parameter int LOG2_W   = 4
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [WIDTH-1:0]  iData,
  input  logic              iData_Valid,
  input  logic [LOG2_W-1:0] iRatio_Log2,
  input  logic [1:0]        iMode,
  input  logic              iClear,
  output logic [WIDTH-1:0]  oData,
  output logic [WIDTH-1:0]  oMin,
  output logic [WIDTH-1:0]  oMax,
  output logic              oData_Valid
);

  localparam int ACC_W = WIDTH + MAX_LOG2;

  logic [MAX_LOG2-1:0] countReg;
  logic [ACC_W-1:0]    accReg;
  logic [WIDTH-1:0]    minReg;
  logic [WIDTH-1:0]    maxReg;
  logic [LOG2_W-1:0]   kActReg;
  logic [1:0]          modeActReg;

  logic                firstSample;
  logic                lastSample;
  logic [LOG2_W-1:0]   kSat;
  logic [LOG2_W-1:0]   kEff;
  logic [1:0]          modeEff;
  logic [MAX_LOG2-1:0] lastIdx;
  logic [ACC_W-1:0]    sumNext;
  logic [WIDTH-1:0]    minNext;
  logic [WIDTH-1:0]    maxNext;
  logic [WIDTH-1:0]    avgNext;
  logic [WIDTH-1:0]    selNext;

  // The first sample of a block sees the live port configuration so that
  // k = 0 blocks and back-to-back blocks need no extra cycle.
  always_comb begin
    firstSample = (countReg == '0);
    kSat        = iRatio_Log2;
    if (iRatio_Log2 > LOG2_W'(MAX_LOG2)) begin
      kSat = LOG2_W'(MAX_LOG2);
    end
    kEff       = firstSample ? kSat  : kActReg;
    modeEff    = firstSample ? iMode : modeActReg;
    lastIdx    = ~({MAX_LOG2{1'b1}} << kEff);
    lastSample = (countReg == lastIdx);
  end

  always_comb begin
    sumNext = firstSample ? ACC_W'(iData) : accReg + ACC_W'(iData);
    minNext = iData;
    maxNext = iData;
    if (!firstSample) begin
      if (minReg < iData) minNext = minReg;
      if (maxReg > iData) maxNext = maxReg;
    end
    avgNext = WIDTH'(sumNext >> kEff);
    case (modeEff)
      2'd1:    selNext = avgNext;
      2'd2:    selNext = maxNext;
      default: selNext = iData;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      countReg    <= '0;
      accReg      <= '0;
      minReg      <= '0;
      maxReg      <= '0;
      kActReg     <= '0;
      modeActReg  <= '0;
      oData       <= '0;
      oMin        <= '0;
      oMax        <= '0;
      oData_Valid <= 1'b0;
    end else begin
      oData_Valid <= 1'b0;
      // Clear wins over a same-cycle sample, which is dropped.
      if (iClear) begin
        countReg <= '0;
      end else if (iData_Valid) begin
        accReg <= sumNext;
        minReg <= minNext;
        maxReg <= maxNext;
        if (firstSample) begin
          kActReg    <= kSat;
          modeActReg <= iMode;
        end
        if (lastSample) begin
          countReg    <= '0;
          oData       <= selNext;
          oMin        <= minNext;
          oMax        <= maxNext;
          oData_Valid <= 1'b1;
        end else begin
          countReg <= countReg + MAX_LOG2'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_decimator.sv
// Self-checking bench for decimator: directed vector table, hand-written corner
// sequences and randomized traffic against a block-queue reference model.
module tb_decimator;

  logic       iClk;
  logic       iRst;
  logic [7:0] iData;
  logic       iData_Valid;
  logic [3:0] iRatio_Log2;
  logic [1:0] iMode;
  logic       iClear;
  logic [7:0] oData;
  logic [7:0] oMin;
  logic [7:0] oMax;
  logic       oData_Valid;

  decimator #(.WIDTH(8), .MAX_LOG2(14), .LOG2_W(4)) dut (
    .iClk(iClk), .iRst(iRst), .iData(iData), .iData_Valid(iData_Valid),
    .iRatio_Log2(iRatio_Log2), .iMode(iMode), .iClear(iClear),
    .oData(oData), .oMin(oMin), .oMax(oMax), .oData_Valid(oData_Valid)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int checks = 0;
  int failures = 0;
  int strobeCount = 0;

  // Reference model: samples of the open block and the configuration it latched
  int blk[$];
  int mk = 0;
  int mm = 0;
  int holdD = 0;
  int holdMin = 0;
  int holdMax = 0;

  typedef struct {
    logic [7:0] data;
    logic       expValid;
    logic [7:0] expData;
    logic [7:0] expMin;
    logic [7:0] expMax;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic step(input int d, input bit v, input bit clr);
    bit expV;
    int sum;
    iData       = d[7:0];
    iData_Valid = v;
    iClear      = clr;
    expV = 1'b0;
    if (clr) begin
      blk.delete();
    end else if (v) begin
      if (blk.size() == 0) begin
        mk = (int'(iRatio_Log2) > 14) ? 14 : int'(iRatio_Log2);
        mm = (iMode == 2'd3) ? 0 : int'(iMode);
      end
      blk.push_back(d);
      if (blk.size() == (1 << mk)) begin
        sum = 0;
        holdMin = 255;
        holdMax = 0;
        foreach (blk[i]) begin
          sum += blk[i];
          if (blk[i] < holdMin) holdMin = blk[i];
          if (blk[i] > holdMax) holdMax = blk[i];
        end
        case (mm)
          1:       holdD = sum / (1 << mk);
          2:       holdD = holdMax;
          default: holdD = blk[blk.size()-1];
        endcase
        expV = 1'b1;
        blk.delete();
      end
    end
    @(posedge iClk);
    #1;
    chk("valid", int'(oData_Valid), int'(expV));
    if (oData_Valid) begin
      strobeCount++;
      $display("strobe k=%0d mode=%0d data=%0d min=%0d max=%0d", mk, mm, oData, oMin, oMax);
    end
    chk("data", int'(oData), holdD);
    chk("min", int'(oMin), holdMin);
    chk("max", int'(oMax), holdMax);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0);
  endtask

  initial begin
    int startCount;

    vecs[0]  = '{8'd1,  1'b0, 8'd0,  8'd0, 8'd0};
    vecs[1]  = '{8'd2,  1'b0, 8'd0,  8'd0, 8'd0};
    vecs[2]  = '{8'd3,  1'b0, 8'd0,  8'd0, 8'd0};
    vecs[3]  = '{8'd4,  1'b1, 8'd4,  8'd1, 8'd4};
    vecs[4]  = '{8'd5,  1'b0, 8'd4,  8'd1, 8'd4};
    vecs[5]  = '{8'd6,  1'b0, 8'd4,  8'd1, 8'd4};
    vecs[6]  = '{8'd7,  1'b0, 8'd4,  8'd1, 8'd4};
    vecs[7]  = '{8'd8,  1'b1, 8'd8,  8'd5, 8'd8};
    vecs[8]  = '{8'd9,  1'b0, 8'd8,  8'd5, 8'd8};
    vecs[9]  = '{8'd10, 1'b0, 8'd8,  8'd5, 8'd8};
    vecs[10] = '{8'd11, 1'b0, 8'd8,  8'd5, 8'd8};
    vecs[11] = '{8'd12, 1'b1, 8'd12, 8'd9, 8'd12};

    iRst = 1'b1;
    iData = '0;
    iData_Valid = 1'b0;
    iRatio_Log2 = 4'd2;
    iMode = 2'd0;
    iClear = 1'b0;
    repeat (2) @(posedge iClk);
    #1;
    chk("reset_valid", int'(oData_Valid), 0);
    chk("reset_data", int'(oData), 0);
    chk("reset_min", int'(oMin), 0);
    chk("reset_max", int'(oMax), 0);
    iRst = 1'b0;

    // Sample mode, k = 2, data 1..12 continuous
    for (int i = 0; i < 12; i++) begin
      iData = vecs[i].data;
      iData_Valid = 1'b1;
      @(posedge iClk);
      #1;
      chk("tbl_valid", int'(oData_Valid), int'(vecs[i].expValid));
      chk("tbl_data", int'(oData), int'(vecs[i].expData));
      chk("tbl_min", int'(oMin), int'(vecs[i].expMin));
      chk("tbl_max", int'(oMax), int'(vecs[i].expMax));
      if (oData_Valid) $display("strobe table row=%0d data=%0d", i, oData);
    end
    holdD = 12; holdMin = 9; holdMax = 12;
    idle(2);

    // Average mode, floor of 361/8
    iRatio_Log2 = 4'd3; iMode = 2'd1;
    for (int i = 0; i < 7; i++) step(10 * (i + 1), 1'b1, 1'b0);
    step(81, 1'b1, 1'b0);
    chk("avg_45", int'(oData), 45);
    idle(1);

    // Largest block of full-scale samples
    iRatio_Log2 = 4'd14;
    for (int i = 0; i < 16384; i++) step(255, 1'b1, 1'b0);
    chk("avg_full_scale", int'(oData), 255);
    idle(1);

    // Peak mode with a gap inside the block
    iRatio_Log2 = 4'd2; iMode = 2'd2;
    step(7, 1'b1, 1'b0);
    step(200, 1'b1, 1'b0);
    idle(5);
    step(3, 1'b1, 1'b0);
    step(9, 1'b1, 1'b0);
    chk("peak_max", int'(oData), 200);
    chk("peak_min", int'(oMin), 3);
    idle(1);

    // Configuration change mid-block takes effect on the next block
    iRatio_Log2 = 4'd2; iMode = 2'd0;
    startCount = strobeCount;
    step(77, 1'b1, 1'b0);
    step(77, 1'b1, 1'b0);
    iRatio_Log2 = 4'd1; iMode = 2'd1;
    for (int i = 0; i < 6; i++) step(77, 1'b1, 1'b0);
    chk("boundary_strobes", strobeCount - startCount, 3);
    idle(1);

    // Clear discards a partial block and the same-cycle sample
    iRatio_Log2 = 4'd3; iMode = 2'd1;
    startCount = strobeCount;
    for (int i = 0; i < 5; i++) step(250, 1'b1, 1'b0);
    step(250, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(i * 4, 1'b1, 1'b0);
    chk("clear_strobes", strobeCount - startCount, 1);
    chk("clear_avg", int'(oData), 14);

    // Asynchronous reset mid-block
    iRatio_Log2 = 4'd2; iMode = 2'd0;
    for (int i = 0; i < 4; i++) step(50 + 10 * i, 1'b1, 1'b0);
    step(99, 1'b1, 1'b0);
    step(98, 1'b1, 1'b0);
    #2 iRst = 1'b1;
    #1;
    chk("async_rst_data", int'(oData), 0);
    chk("async_rst_min", int'(oMin), 0);
    chk("async_rst_max", int'(oMax), 0);
    chk("async_rst_valid", int'(oData_Valid), 0);
    iData_Valid = 1'b0;
    @(posedge iClk);
    #1 iRst = 1'b0;
    blk.delete();
    holdD = 0; holdMin = 0; holdMax = 0;
    for (int i = 0; i < 4; i++) step(i + 20, 1'b1, 1'b0);

    // Pass-through, k = 0, every mode
    iRatio_Log2 = 4'd0;
    for (int i = 0; i < 20; i++) begin
      iMode = 2'($urandom_range(0, 3));
      step(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    end

    // Saturated exponent behaves as 14
    iRatio_Log2 = 4'd15; iMode = 2'd1;
    startCount = strobeCount;
    for (int i = 0; i < 16383; i++) step(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("sat_no_early", strobeCount - startCount, 0);
    step(int'($urandom_range(0, 255)), 1'b1, 1'b0);
    chk("sat_strobe", strobeCount - startCount, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        iRatio_Log2 = 4'($urandom_range(0, 4));
        iMode = 2'($urandom_range(0, 3));
      end
      step(int'($urandom_range(0, 255)), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
